// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the PC, selects the next PC (sequential / branch / jump / jr), issues
// word fetches over a req/ack handshake and presents each fetched word with
// its PC+4 to the IF/ID register. A one-entry skid buffer catches a response
// that lands while the output is stalled; the DRAIN state swallows the
// response of a fetch that a redirect squashed while it was outstanding.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   stall               output not consumed this cycle
//   br_taken/br_target  branch redirect (word address)
//   jmp/jmp_index       j/jal redirect (instr_index field)
//   jr/jr_target        jr/jalr redirect (word address)
//   imem_req/imem_addr  fetch request and word address (combinational)
//   imem_ack/imem_rdata fetch response
//   out_valid, out_instruction, out_fourPC  registered IF/ID payload
//   pc                  next sequential fetch address
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:2] br_target,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:2] jr_target,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:2] out_fourPC,
  output logic [31:2] pc
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_d;
  logic [31:2] pc_d;
  logic [31:2] stale_addr, stale_addr_d;
  logic [31:0] skid_instr, skid_instr_d;
  logic [31:2] skid_fourpc, skid_fourpc_d;
  logic        out_valid_d;
  logic [31:0] out_instruction_d;
  logic [31:2] out_fourpc_d;

  logic        redirect;
  logic [31:2] target;
  logic [31:2] pc_inc;

  // Redirect target with jr > jmp > br_taken priority.
  always_comb begin
    redirect = jr | jmp | br_taken;
    target   = br_target;
    if (jr) begin
      target = jr_target;
    end else if (jmp) begin
      target = {out_fourPC[31:28], jmp_index};
    end
  end

  // Word-granular increment wraps naturally mod 2^30.
  assign pc_inc = pc + 30'd1;

  // Next-state and next-register logic.
  always_comb begin
    state_d           = state;
    pc_d              = pc;
    stale_addr_d      = stale_addr;
    skid_instr_d      = skid_instr;
    skid_fourpc_d     = skid_fourpc;
    out_valid_d       = out_valid;
    out_instruction_d = out_instruction;
    out_fourpc_d      = out_fourPC;
    imem_req          = 1'b0;
    imem_addr         = pc;

    case (state)
      FETCH: begin
        imem_req = rst;
        if (imem_ack) begin
          if (redirect) begin
            pc_d        = target;
            out_valid_d = 1'b0;
          end else if (!out_valid || !stall) begin
            out_instruction_d = imem_rdata;
            out_fourpc_d      = pc_inc;
            out_valid_d       = 1'b1;
            pc_d              = pc_inc;
          end else begin
            // Output is held; park the new word in the skid buffer.
            skid_instr_d  = imem_rdata;
            skid_fourpc_d = pc_inc;
            pc_d          = pc_inc;
            state_d       = HOLD;
          end
        end else if (redirect) begin
          // Request still outstanding: remember it so its ack can be dropped.
          stale_addr_d = pc;
          pc_d         = target;
          out_valid_d  = 1'b0;
          state_d      = DRAIN;
        end else if (out_valid && !stall) begin
          out_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          out_valid_d = 1'b0;
          pc_d        = target;
          state_d     = FETCH;
        end else if (!stall) begin
          out_instruction_d = skid_instr;
          out_fourpc_d      = skid_fourpc;
          out_valid_d       = 1'b1;
          state_d           = FETCH;
        end
      end

      DRAIN: begin
        // Keep the squashed request on the bus until memory answers it.
        imem_req  = rst;
        imem_addr = stale_addr;
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= FETCH;
      pc              <= RESET_PC[31:2];
      stale_addr      <= '0;
      skid_instr      <= '0;
      skid_fourpc     <= '0;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_fourPC      <= '0;
    end else begin
      state           <= state_d;
      pc              <= pc_d;
      stale_addr      <= stale_addr_d;
      skid_instr      <= skid_instr_d;
      skid_fourpc     <= skid_fourpc_d;
      out_valid       <= out_valid_d;
      out_instruction <= out_instruction_d;
      out_fourPC      <= out_fourpc_d;
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC, selects the next PC from sequential/branch/jump/jr sources, and issues word fetches to instruction memory over a req/ack handshake. It presents each fetched word with its PC+4 to the IF/ID pipeline register. A one-entry skid buffer absorbs a response that arrives while the pipeline is stalled, and a drain state discards responses belonging to squashed fetches.

## Interface
- RESET_PC, 32'h0000_3000, byte address of the first fetch; bits [1:0] are ignored.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  hazard hold; the current output is not consumed this cycle.
- br_taken  in  1  branch redirect from ID.
- br_target  in  [31:2]  branch target word address.
- jmp  in  1  j/jal redirect from ID.
- jmp_index  in  [25:0]  instr_index field.
- jr  in  1  jr/jalr redirect from ID.
- jr_target  in  [31:2]  register target word address.
- imem_req  out  1  fetch request.
- imem_addr  out  [31:2]  fetch word address.
- imem_ack  in  1  response valid; may be asserted in the same cycle as imem_req.
- imem_rdata  in  [31:0]  fetched instruction.
- out_valid  out  1  out_instruction and out_fourPC are valid.
- out_instruction  out  [31:0]  fetched word.
- out_fourPC  out  [31:2]  PC+4 of that word.
- pc  out  [31:2]  next sequential fetch address.

## Operation
- Registers: pc, stale_addr, skid_instr, skid_fourPC, state ∈ {FETCH, HOLD, DRAIN}, and the three output registers.
- Redirect priority: jr > jmp > br_taken.
  - jr target = jr_target.
  - jmp target = {out_fourPC[31:28], jmp_index}.
  - br target = br_target.
- redirect = jr | jmp | br_taken. A redirect overrides stall.
- Consumption: an output is consumed at an edge where out_valid=1 and stall=0.
- All PC arithmetic is word-granular mod 2^30. fourPC = pc+1, so 30'h3FFFFFFF wraps to 0.
- FETCH: imem_req=1, imem_addr=pc.
  - ack & redirect: discard rdata; pc<=target; out_valid<=0; stay in FETCH.
  - ack & (!out_valid | !stall): output<=(rdata, pc+1); out_valid<=1; pc<=pc+1.
  - ack & out_valid & stall: skid<=(rdata, pc+1); pc<=pc+1; go to HOLD. The current output is held.
  - no ack & redirect: stale_addr<=pc; pc<=target; out_valid<=0; go to DRAIN.
  - no ack, output consumed: out_valid<=0.
- HOLD: imem_req=0.
  - redirect: drop skid; out_valid<=0; pc<=target; go to FETCH.
  - stall=0: output<=skid; out_valid<=1; go to FETCH.
- DRAIN: imem_req=1, imem_addr=stale_addr (request held until ack); out_valid=0.
  - ack: discard; go to FETCH.
  - A further redirect updates pc only.
- An instruction is never lost, duplicated, or delivered after a redirect that squashes it.

## Timing
- Reset (rst=0 at an edge):
  - pc<=RESET_PC[31:2]; state<=FETCH.
  - out_valid=0, out_instruction=0, out_fourPC=0, skid=0, stale_addr=0.
  - imem_req=0 while rst=0 (combinational gating).
  - Reset mid-operation aborts everything at that edge. Any later ack for the aborted request is an environment error and is not handled.
- First request: in the first cycle with rst=1, imem_addr=RESET_PC[31:2].
- Latency: ack at edge N puts the data on the outputs after edge N (registered). With zero-wait memory, throughput is one instruction per cycle.
- imem_addr changes only at an edge where ack=1 or where the state changes.
- Outputs are stable while out_valid=1 and stall=1.
- Skid exit: on the cycle after HOLD releases, imem_req is 1 at the address following the skid word.

## Test plan
- Reset and start: hold rst=0 for 2 cycles -> outputs 0 and imem_req=0. Release -> imem_req=1, imem_addr=30'h0000_0C00.
- Zero-wait stream: ack=1 every cycle, rdata=addr -> out_fourPC = 0C01, 0C02, 0C03… on consecutive cycles with out_valid=1.
- Skid:
  - Stimulus: stall=1 while out_valid=1, then ack for 0C02 arrives.
  - Response: state HOLD, imem_req=0, outputs held at the 0C01 word.
  - Stimulus: drop stall.
  - Response: next output is the 0C02 word, then a fetch of 0C03. No gaps and no duplicates.
- Drain:
  - Stimulus: ack delayed 3 cycles; br_taken with br_target=30'h100 one cycle after the request.
  - Response: imem_addr stays at the old address until ack, the acked data is discarded, the next request is to 30'h100, and out_valid=0 throughout.
- Priority:
  - Stimulus: jr=1 (jr_target=30'h200) and br_taken=1 in the same cycle as an ack.
  - Response: data discarded, next imem_addr=30'h200.
  - Also: jmp with out_fourPC[31:28]=4'h0, jmp_index=26'h10 -> next address 30'h10.
- Reset in HOLD and wrap-around:
  - rst=0 while in HOLD -> all outputs 0 at the next edge.
  - Fetch at pc=30'h3FFFFFFF -> out_fourPC=0.
